risc16_mem_arbiter: RTL

- Arbitrates one single-port synchronous RAM (1-cycle read latency) between the RiSC-16 core's instruction-fetch port and its load/store data port.
- Sits between the core and the block RAM inside top.
- Data port has fixed priority, with a bounded-streak starvation guard for fetch.
- Throughput is one transaction per cycle; back-to-back grants are allowed.

---
 rtl/risc16_mem_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/risc16_mem_arbiter.sv
// risc16_mem_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// RiSC-16 instruction-fetch port and the load/store data port.
//   clk, rst              : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_gnt
//   if_gnt                : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata    : fetch read data, one cycle after grant
//   d_req/d_we/d_addr/d_wdata : load/store request, held until d_gnt
//   d_gnt                 : data request accepted this cycle (combinational)
//   d_rvalid/d_rdata      : load read data, one cycle after grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM port
// Data port has priority; after MAX_DATA_STREAK data grants in a row while a
// fetch is waiting, the fetch is forced through.
module risc16_mem_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  owner_t     rd_owner, rd_owner_nxt;
  logic [3:0] streak, streak_nxt;
  logic       force_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
      streak   <= '0;
    end else begin
      rd_owner <= rd_owner_nxt;
      streak   <= streak_nxt;
    end
  end

  always_comb begin
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rd_owner_nxt = OWN_NONE;
    streak_nxt   = streak;
    force_if     = if_req & d_req & (streak == STREAK_MAX);

    if (!rst) begin
      if (force_if)    if_gnt = 1'b1;
      else if (d_req)  d_gnt  = 1'b1;
      else if (if_req) if_gnt = 1'b1;
    end

    if (if_gnt) begin
      mem_en       = 1'b1;
      mem_addr     = if_addr;
      mem_wdata    = d_wdata;
      rd_owner_nxt = OWN_IF;
    end else if (d_gnt) begin
      mem_en       = 1'b1;
      mem_we       = d_we;
      mem_addr     = d_addr;
      mem_wdata    = d_wdata;
      // stores complete at the grant edge and return nothing
      rd_owner_nxt = d_we ? OWN_NONE : OWN_D;
    end

    // streak counts data grants that made a waiting fetch lose
    if (if_gnt || !if_req)
      streak_nxt = '0;
    else if (d_gnt && streak != STREAK_MAX)
      streak_nxt = streak + 4'd1;
  end

  // gating with rst drops a read that was granted just before reset
  assign if_rvalid = (rd_owner == OWN_IF) && !rst;
  assign d_rvalid  = (rd_owner == OWN_D)  && !rst;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule
